// File: rtl/systolic_pkg.sv
// systolic_pkg: definitions shared by the systolic array and its input feeder.
//   DEF_ARRAY_SIZE / DEF_DATA_WIDTH : default tile dimension and operand width
//   feeder_state_t                  : feeder FSM states (LOAD, FEED)
//   lane_t                          : one operand lane at the default width
//   ctr_width()                     : bit width of a counter holding 0..n-1
package systolic_pkg;

  localparam int DEF_ARRAY_SIZE = 8;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic {
    LOAD = 1'b0,
    FEED = 1'b1
  } feeder_state_t;

  typedef logic [DEF_DATA_WIDTH-1:0] lane_t;

  // A counter for 0..n-1 never gets narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_select.sv
// skew_select: combinational diagonal-skew picker for one lane.
//   col  : the N operands this lane will ever carry, in k order
//   lane : lane index i (the lane's skew in cycles)
//   t    : current feed step
//   elem : col[t-i] when 0 <= t-i <= N-1, otherwise all zero
module skew_select
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int KW = ctr_width(ARRAY_SIZE),
  localparam int TW = ctr_width(2 * ARRAY_SIZE - 1)
) (
  input  logic [DATA_WIDTH-1:0] col [ARRAY_SIZE],
  input  logic [KW-1:0]         lane,
  input  logic [TW-1:0]         t,
  output logic [DATA_WIDTH-1:0] elem
);

  // One guard bit so t < lane is detected instead of wrapping.
  logic [TW:0] t_ext_s;
  logic [TW:0] lane_ext_s;
  logic [TW:0] diff_s;

  // Window test and element pick; anything outside the window is forced to zero.
  always_comb begin
    t_ext_s    = {1'b0, t};
    lane_ext_s = (TW + 1)'(lane);
    diff_s     = t_ext_s - lane_ext_s;
    if ((t_ext_s >= lane_ext_s) && (diff_s < (TW + 1)'(ARRAY_SIZE))) begin
      elem = col[diff_s[KW-1:0]];
    end else begin
      elem = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one A/B tile (one k-slice per load beat) and streams
// it into the systolic array with lane i delayed i cycles and zero fill.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : load handshake; in_ready is high only in LOAD
//   in_a_col[i]          : A[i][k] for beat k
//   in_b_row[j]          : B[k][j] for beat k
//   a_lanes / b_lanes    : registered skewed operands to the array
//   out_valid            : high on each of the 2N-1 feed cycles
//   out_first/tile_done  : first / last feed cycle of a tile
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a_col [ARRAY_SIZE],
  input  logic [DATA_WIDTH-1:0] in_b_row [ARRAY_SIZE],
  output logic [DATA_WIDTH-1:0] a_lanes  [ARRAY_SIZE],
  output logic [DATA_WIDTH-1:0] b_lanes  [ARRAY_SIZE],
  output logic                  out_valid,
  output logic                  out_first,
  output logic                  tile_done
);

  localparam int KW = ctr_width(ARRAY_SIZE);
  localparam int TW = ctr_width(2 * ARRAY_SIZE - 1);
  localparam logic [KW-1:0] K_LAST = KW'(ARRAY_SIZE - 1);
  localparam logic [TW-1:0] T_LAST = TW'(2 * ARRAY_SIZE - 2);

  // Buffers are stored lane-major ([lane][k]) so each lane's column is a plain slice.
  logic [DATA_WIDTH-1:0] buf_a_q [ARRAY_SIZE][ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] buf_a_d [ARRAY_SIZE][ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] buf_b_q [ARRAY_SIZE][ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] buf_b_d [ARRAY_SIZE][ARRAY_SIZE];

  feeder_state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [TW-1:0] t_q, t_d;
  logic          load_fire_s;
  logic          feed_s;

  // The select stage lags the FSM by one cycle, so LOAD (in_ready) reopens
  // while the last slice is still being selected.
  logic [TW-1:0] sel_t_q, sel_t_d;
  logic          sel_valid_q, sel_valid_d;

  logic [DATA_WIDTH-1:0] a_sel_s [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] b_sel_s [ARRAY_SIZE];

  logic [DATA_WIDTH-1:0] a_lanes_q [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] a_lanes_d [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] b_lanes_q [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] b_lanes_d [ARRAY_SIZE];
  logic out_valid_q, out_valid_d;
  logic out_first_q, out_first_d;
  logic tile_done_q, tile_done_d;

  assign in_ready  = (state_q == LOAD);
  assign a_lanes   = a_lanes_q;
  assign b_lanes   = b_lanes_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign tile_done = tile_done_q;

  // Next-state logic: beat counting in LOAD, step counting in FEED.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    t_d         = t_q;
    load_fire_s = 1'b0;
    feed_s      = 1'b0;
    case (state_q)
      LOAD: begin
        load_fire_s = in_valid;
        if (in_valid) begin
          if (k_q == K_LAST) begin
            state_d = FEED;
            k_d     = {KW{1'b0}};
            t_d     = {TW{1'b0}};
          end else begin
            k_d = k_q + KW'(1);
          end
        end else begin
          k_d = k_q;
        end
      end
      FEED: begin
        feed_s = 1'b1;
        if (t_q == T_LAST) begin
          state_d = LOAD;
          t_d     = {TW{1'b0}};
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      default: begin
        state_d = LOAD;
        k_d     = {KW{1'b0}};
        t_d     = {TW{1'b0}};
      end
    endcase
  end

  // Buffer write: an accepted beat fills slot k of every lane.
  always_comb begin
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    if (load_fire_s) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        buf_a_d[i][k_q] = in_a_col[i];
        buf_b_d[i][k_q] = in_b_row[i];
      end
    end else begin
      buf_b_d = buf_b_q;
    end
  end

  // Select-stage inputs; t is parked at zero while idle.
  always_comb begin
    sel_valid_d = feed_s;
    if (feed_s) begin
      sel_t_d = t_q;
    end else begin
      sel_t_d = {TW{1'b0}};
    end
  end

  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    skew_select #(
      .ARRAY_SIZE(ARRAY_SIZE),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_sel_a (
      .col (buf_a_q[gi]),
      .lane(KW'(gi)),
      .t   (sel_t_q),
      .elem(a_sel_s[gi])
    );
    skew_select #(
      .ARRAY_SIZE(ARRAY_SIZE),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_sel_b (
      .col (buf_b_q[gi]),
      .lane(KW'(gi)),
      .t   (sel_t_q),
      .elem(b_sel_s[gi])
    );
  end

  // Output stage; lanes are gated so idle cycles never expose buffer contents.
  always_comb begin
    a_lanes_d   = '{default: {DATA_WIDTH{1'b0}}};
    b_lanes_d   = '{default: {DATA_WIDTH{1'b0}}};
    out_valid_d = sel_valid_q;
    out_first_d = sel_valid_q && (sel_t_q == {TW{1'b0}});
    tile_done_d = sel_valid_q && (sel_t_q == T_LAST);
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      if (sel_valid_q) begin
        a_lanes_d[i] = a_sel_s[i];
        b_lanes_d[i] = b_sel_s[i];
      end else begin
        a_lanes_d[i] = {DATA_WIDTH{1'b0}};
        b_lanes_d[i] = {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Control, select-stage and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      k_q         <= {KW{1'b0}};
      t_q         <= {TW{1'b0}};
      sel_t_q     <= {TW{1'b0}};
      sel_valid_q <= 1'b0;
      a_lanes_q   <= '{default: {DATA_WIDTH{1'b0}}};
      b_lanes_q   <= '{default: {DATA_WIDTH{1'b0}}};
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      t_q         <= t_d;
      sel_t_q     <= sel_t_d;
      sel_valid_q <= sel_valid_d;
      a_lanes_q   <= a_lanes_d;
      b_lanes_q   <= b_lanes_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Tile buffer storage; contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    buf_a_q <= buf_a_d;
    buf_b_q <= buf_b_d;
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed bench for systolic_feeder at N=4, 8-bit data.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a_col [N];
  logic [DW-1:0] in_b_row [N];
  logic [DW-1:0] a_lanes  [N];
  logic [DW-1:0] b_lanes  [N];
  logic          out_valid;
  logic          out_first;
  logic          tile_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Tile slots: ta[s][i][k] = A[i][k], tb[s][k][j] = B[k][j].
  logic [DW-1:0] ta [3][N][N];
  logic [DW-1:0] tb [3][N][N];

  systolic_feeder #(
    .ARRAY_SIZE(N),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a_col (in_a_col),
    .in_b_row (in_b_row),
    .a_lanes  (a_lanes),
    .b_lanes  (b_lanes),
    .out_valid(out_valid),
    .out_first(out_first),
    .tile_done(tile_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_a(input int s, input int i, input int t);
    if (t >= i && t - i < N) return ta[s][i][t-i];
    return 8'h00;
  endfunction

  function automatic logic [DW-1:0] exp_b(input int s, input int j, input int t);
    if (t >= j && t - j < N) return tb[s][t-j][j];
    return 8'h00;
  endfunction

  task automatic drive_beat(input int s, input int k);
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_a_col[i] = ta[s][i][k];
      in_b_row[i] = tb[s][k][i];
    end
  endtask

  task automatic drive_junk(input logic v);
    in_valid = v;
    for (int i = 0; i < N; i++) begin
      in_a_col[i] = 8'hEE;
      in_b_row[i] = 8'hDD;
    end
  endtask

  // Loads slot s; 'gap' idle cycles are inserted between beats 1 and 2.
  // Returns right after the edge that accepts the last beat.
  task automatic load_tile(input int s, input int gap);
    for (int k = 0; k < N; k++) begin
      if (k == 2) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check_eq("gap_rdy", {31'd0, in_ready}, 32'd1);
          check_eq("gap_ov", {31'd0, out_valid}, 32'd0);
          drive_junk(1'b0);
        end
      end
      @(negedge clk);
      check_eq($sformatf("ld_rdy_k%0d", k), {31'd0, in_ready}, 32'd1);
      drive_beat(s, k);
    end
    @(posedge clk);
  endtask

  // Entered just after edge E (last beat accepted). Sample c is taken after
  // edge E+c; feed step t = c-2 is visible for c = 2..8.
  // mode 0: idle inputs; mode 1: junk with in_valid=1 while in FEED;
  // mode 2: load slot ns back-to-back, beats at c = 7..10.
  task automatic check_feed(input int s, input int mode, input int ns);
    int t;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      t = c - 2;
      check_eq($sformatf("ov_c%0d", c), {31'd0, out_valid}, {31'd0, (c >= 2 && c <= 8)});
      check_eq($sformatf("first_c%0d", c), {31'd0, out_first}, {31'd0, (c == 2)});
      check_eq($sformatf("done_c%0d", c), {31'd0, tile_done}, {31'd0, (c == 8)});
      check_eq($sformatf("rdy_c%0d", c), {31'd0, in_ready}, {31'd0, (c >= 7)});
      for (int i = 0; i < N; i++) begin
        check_eq($sformatf("a%0d_c%0d", i, c), {24'd0, a_lanes[i]},
                 (c >= 2 && c <= 8) ? {24'd0, exp_a(s, i, t)} : 32'd0);
        check_eq($sformatf("b%0d_c%0d", i, c), {24'd0, b_lanes[i]},
                 (c >= 2 && c <= 8) ? {24'd0, exp_b(s, i, t)} : 32'd0);
      end
      if (mode == 1 && c <= 6) begin
        drive_junk(1'b1);
      end else if (mode == 2 && c >= 7) begin
        drive_beat(ns, c - 7);
      end else begin
        drive_junk(1'b0);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_first"}, {31'd0, out_first}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, tile_done}, 32'd0);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("%s_a%0d", tag, i), {24'd0, a_lanes[i]}, 32'd0);
      check_eq($sformatf("%s_b%0d", tag, i), {24'd0, b_lanes[i]}, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        ta[0][i][k] = (i == k) ? 8'd1 : 8'd0;
        tb[0][i][k] = (i == k) ? 8'd1 : 8'd0;
        ta[1][i][k] = 8'(16 * i + k + 1);
        tb[1][i][k] = 8'(16 * i + k + 1);
        ta[2][i][k] = 8'(8'hC0 - 8 * i - k);
        tb[2][i][k] = 8'(8'h70 + 5 * i + 3 * k);
      end
    end

    rst = 1'b1;
    drive_junk(1'b0);
    repeat (2) @(negedge clk);
    check_idle_outputs("rst_in");
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_rdy", {31'd0, in_ready}, 32'd1);
    check_idle_outputs("rst_out");

    // Identity tile: lane i carries a 1 only at feed step 2i.
    load_tile(0, 0);
    check_feed(0, 0, 0);

    // Distinct values: full skew window and zero fill.
    load_tile(1, 0);
    check_feed(1, 0, 0);

    // Three idle cycles between beats 1 and 2.
    load_tile(2, 3);
    check_feed(2, 0, 0);

    // Junk presented with in_valid=1 throughout FEED.
    load_tile(1, 0);
    check_feed(1, 1, 0);

    // Back-to-back: tile 2 starts on the cycle in_ready returns.
    load_tile(1, 0);
    check_feed(1, 2, 2);
    @(posedge clk);
    check_feed(2, 0, 0);

    // Reset at feed step 3: outputs clear at once, no tile_done follows.
    load_tile(1, 0);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      drive_junk(1'b0);
    end
    check_eq("pre_rst_ov", {31'd0, out_valid}, 32'd1);
    check_eq("pre_rst_a3", {24'd0, a_lanes[3]}, {24'd0, exp_a(1, 3, 3)});
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_eq($sformatf("post_rst_done_%0d", c), {31'd0, tile_done}, 32'd0);
      check_eq($sformatf("post_rst_ov_%0d", c), {31'd0, out_valid}, 32'd0);
    end

    load_tile(2, 0);
    check_feed(2, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input-side scheduler for the NxN systolic array. Accepts one tile of A (N×N) and B (N×N) over a ready/valid load interface, one k-slice per beat, and buffers it. It then streams the operands into the array's `a_inputs`/`b_inputs` lanes with the diagonal skew a weight/activation-stationary-free output-flow array needs. Lane i is delayed i cycles, and out-of-window slots are zero-filled so they add nothing to the MAC chain. It sits between the tile buffers/DMA and the array.

## Interface
- `ARRAY_SIZE`, 8: N, number of lanes and tile dimension; at least 2.
- `DATA_WIDTH`, 8: operand width.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: load beat valid.
- `in_ready` output 1: feeder can accept a load beat.
- `in_a_col` input [DATA_WIDTH-1:0] ×N (unpacked): beat k carries A[i][k] on element i.
- `in_b_row` input [DATA_WIDTH-1:0] ×N (unpacked): beat k carries B[k][j] on element j.
- `a_lanes` output [DATA_WIDTH-1:0] ×N: to array `a_inputs`.
- `b_lanes` output [DATA_WIDTH-1:0] ×N: to array `b_inputs`.
- `out_valid` output 1: to array `valid_in`; high on every feed cycle.
- `out_first` output 1: high with the first feed cycle of a tile.
- `tile_done` output 1: one-cycle pulse coincident with the last feed cycle.

## Operation
- States: LOAD and FEED. Reset state is LOAD.
- **LOAD:**
  - `in_ready`=1.
  - Each handshake (`in_valid`&`in_ready`) writes slice k into buffer row k, where k is the beat counter from 0 to N-1.
  - The beat that makes k=N-1 moves the block to FEED with t=0 and k cleared.
  - `in_valid` low means no write and no state change.
- **FEED:**
  - `in_ready`=0, and load inputs are ignored.
  - t counts from 0 to 2N-2, one step per cycle, with no stalls. The array has no backpressure.
  - For each t, lane i selects A[i][t-i] when 0 ≤ t-i ≤ N-1, and 0 otherwise.
  - Lane j selects B[t-j][j] under the same rule.
  - After t=2N-2 the block returns to LOAD with k=0.
- Zero-fill is exact: out-of-window lanes carry all-zero data, never stale buffer contents.
- The buffer is a single tile of 2·N·N·DATA_WIDTH bits with no double buffering. A new tile is accepted only after the previous feed has issued its last slice.
- Counters: k is $clog2(N) bits and t is $clog2(2N-1) bits. There is no wrap except the explicit reset to 0 at each terminal count.

## Timing
- Outputs are registered: one register stage after the skew select.
- Let E be the edge that accepts load beat N-1.
  - FEED selection runs on cycles E+1 … E+2N-1.
  - `out_valid` is high for the 2N-1 cycles following E+1, first visible after edge E+2.
  - `out_first` is high on the first of those cycles.
  - `tile_done` is high on the last of those cycles.
- `in_ready` rises on the cycle that the last FEED slice is registered. That is one cycle before `tile_done` is visible, so back-to-back tiles overlap by one cycle.
- Load throughput: one beat per cycle. Minimum tile period is N + 2N-1 cycles.
- Reset values:
  - `in_ready`=1 after reset release (0 while `rst` is asserted is not required; 1 is acceptable).
  - `a_lanes`/`b_lanes` = 0.
  - `out_valid`, `out_first`, `tile_done` = 0.
  - State LOAD, k=0, t=0.
  - Buffer contents are not reset.
- Reset mid-LOAD or mid-FEED:
  - The partial tile is discarded.
  - Outputs return to 0 immediately (asynchronously).
  - No `tile_done` is issued for the aborted tile.
- `in_valid` held high while `in_ready`=0 has no effect. The upstream holds its data per standard ready/valid.

## Structure
- `systolic_pkg` holds:
  - the default `ARRAY_SIZE`/`DATA_WIDTH` constants;
  - the `feeder_state_t` enum {LOAD, FEED};
  - a `lane_t` typedef for `logic [DATA_WIDTH-1:0]`.
- The array and the feeder share the package so lane widths cannot drift.
- One sub-module, `skew_select`, instantiated once per lane for A and once per lane for B. It takes the buffer column, lane index and t, and returns the in-window element or zero. It is combinational.
- The top level holds the buffer, counters, FSM and output registers.

## Test plan
Scenarios use N=4 and DATA_WIDTH=8.

- **Basic tile:** load A = B = identity in 4 consecutive beats. Check that:
  - `out_valid` is high for exactly 7 cycles starting 2 cycles after the last beat's edge;
  - lane i is nonzero (value 1) only at feed cycle 2i;
  - `out_first` and `tile_done` are each single pulses.
- **Skew and zero-fill:** load A[i][k]=16i+k+1 and B[k][j]=16k+j+1. Check every lane on every feed cycle against the t-i window rule, with zeros outside the window.
- **Load gaps:** drop `in_valid` for 3 cycles between beats 1 and 2. Check that:
  - beat count and data are unchanged;
  - FEED starts only after the 4th handshake;
  - `in_ready` stays 1 throughout.
- **Back-to-back tiles:** present tile 2 continuously. Check that:
  - `in_ready` returns on the last feed cycle of tile 1;
  - tile 2's first `out_valid` follows after 4 beats plus 1 cycle;
  - no tile-1 data appears in tile 2.
- **Ignored input during FEED:** hold `in_valid`=1 with garbage data during FEED. Check that the fed data is unaffected and nothing is written.
- **Reset mid-FEED:** assert `rst` at feed cycle 3. Check that:
  - all outputs go to 0 asynchronously;
  - `in_ready` is 1 after release;
  - no `tile_done` is issued;
  - a fresh tile then feeds correctly.
